// File: rtl/ffm_pkg.sv
// Shared types and helpers for the GF(2^m) multiplier operand sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ffm_pkg;

    // Build configuration of the sequencer (digit width, digit count, core latency)
    localparam int FFM_W       = 16;
    localparam int FFM_N       = 11;
    localparam int FFM_RES_DLY = 22;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STREAM  = 3'd1,
        WAIT    = 3'd2,
        COLLECT = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Counters must reach RES_DLY+N-1 plus one step of headroom past the stream end
    function automatic int cnt_w(input int res_dly, input int n);
        return $clog2(res_dly + n + 2);
    endfunction

    localparam int FFM_CNT_W = cnt_w(FFM_RES_DLY, FFM_N);

    // W-bit digit k of an N-digit operand (digit 0 is least significant)
    function automatic logic [FFM_W-1:0] digit(input logic [FFM_N*FFM_W-1:0] vec, input int k);
        return vec[k*FFM_W +: FFM_W];
    endfunction

endpackage

// File: rtl/ffm_digit_shifter.sv
// N-digit register: parallel load, one-digit left shift with W-bit insert at digit 0.
// Latency: 1 cycle from load/shift to data/head.
// Backpressure: none; load has priority over shift, the caller gates both.
module ffm_digit_shifter
    import ffm_pkg::*;
#(
    parameter int W = FFM_W,
    parameter int N = FFM_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N*W-1:0] load_data,
    input  logic           shift,
    input  logic [W-1:0]   shift_in,
    output logic [N*W-1:0] data,
    output logic [W-1:0]   head
);

    // Digits move towards the MS end, so the head is always the next digit out and
    // the first digit shifted in ends up in digit N-1 after N shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= (data << W) | (N*W)'(shift_in);
        end
    end

    assign head = data[(N-1)*W +: W];

endmodule

// File: rtl/ffm_operand_sequencer.sv
// Word-serial front/back end for the systolic GF(2^m) multiplier: streams A/B/G MS-digit-first, collects N product digits.
// Latency: 1+RES_DLY+N cycles from operand handshake to res_valid; one idle bubble between operations.
// Backpressure: op_ready only in IDLE; result held in DONE until res_ready. Optional FFM_OP_COUNT_EN adds op_count.
module ffm_operand_sequencer
    import ffm_pkg::*;
#(
    parameter int W       = FFM_W,
    parameter int N       = FFM_N,
    parameter int RES_DLY = FFM_RES_DLY
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [N*W-1:0] op_a,
    input  logic [N*W-1:0] op_b,
    input  logic [N*W-1:0] op_g,
    output logic           ffm_ctr,
    output logic [W-1:0]   ffm_a,
    output logic [W-1:0]   ffm_b,
    output logic [W-1:0]   ffm_g,
    input  logic [W-1:0]   ffm_p,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N*W-1:0] res_data
`ifdef FFM_OP_COUNT_EN
    ,
    output logic [31:0]    op_count
`endif
);

    localparam int              CNT_W   = cnt_w(RES_DLY, N);
    localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(N);
    localparam logic [CNT_W-1:0] C_FIRST = CNT_W'(RES_DLY);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(RES_DLY + N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] t_cnt;      // stream slot of the current cycle
    logic [CNT_W-1:0] c_cnt;      // cycles since the first ctr=1 slot
    logic [CNT_W-1:0] c_inc;
    logic             op_fire;
    logic             res_fire;
    logic             stream_shift;
    logic             col_en;
    logic             ctr_d;
    logic [W-1:0]     a_d;
    logic [W-1:0]     b_d;
    logic [W-1:0]     g_d;
    logic [W-1:0]     a_head;
    logic [W-1:0]     b_head;
    logic [W-1:0]     g_head;
    logic [N*W-1:0]   b_load;
    logic [N*W-1:0]   unused_a_data;
    logic [N*W-1:0]   unused_b_data;
    logic [N*W-1:0]   unused_g_data;
    logic [W-1:0]     unused_res_head;

    assign op_ready  = (state == IDLE);
    assign res_valid = (state == DONE);
    assign op_fire   = op_valid & op_ready;
    assign res_fire  = res_valid & res_ready;
    assign c_inc     = c_cnt + 1'b1;

    // B leads by one slot: its MS digit goes straight to the core register at the
    // handshake, so the shifter holds the remaining digits with zero fill below.
    assign b_load = op_b << W;

    ffm_digit_shifter #(.W(W), .N(N)) u_a_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (op_fire),
        .load_data (op_a),
        .shift     (stream_shift),
        .shift_in  ('0),
        .data      (unused_a_data),
        .head      (a_head)
    );

    ffm_digit_shifter #(.W(W), .N(N)) u_g_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (op_fire),
        .load_data (op_g),
        .shift     (stream_shift),
        .shift_in  ('0),
        .data      (unused_g_data),
        .head      (g_head)
    );

    ffm_digit_shifter #(.W(W), .N(N)) u_b_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (op_fire),
        .load_data (b_load),
        .shift     (stream_shift),
        .shift_in  ('0),
        .data      (unused_b_data),
        .head      (b_head)
    );

    ffm_digit_shifter #(.W(W), .N(N)) u_res_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift     (col_en),
        .shift_in  (ffm_p),
        .data      (res_data),
        .head      (unused_res_head)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; the stream end may skip WAIT when collection already started
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (op_fire) state_nxt = STREAM;
            end
            STREAM: begin
                if (t_cnt == T_LAST) begin
                    if (c_cnt >= C_LAST)       state_nxt = DONE;
                    else if (c_inc >= C_FIRST) state_nxt = COLLECT;
                    else                       state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (c_inc >= C_FIRST) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (c_cnt == C_LAST) state_nxt = DONE;
            end
            DONE: begin
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Core-side values for the next cycle and datapath enables
    always_comb begin
        a_d          = '0;
        b_d          = '0;
        g_d          = '0;
        stream_shift = (state == STREAM) && (t_cnt != T_LAST);
        if (op_fire) begin
            b_d = op_b[(N-1)*W +: W];
        end
        if (stream_shift) begin
            a_d = a_head;
            g_d = g_head;
            b_d = b_head;
        end
        ctr_d  = ((state == STREAM) && (state_nxt == STREAM)) ||
                 (state_nxt == WAIT) || (state_nxt == COLLECT);
        col_en = ((state == STREAM && t_cnt != '0) || state == WAIT || state == COLLECT) &&
                 (c_cnt >= C_FIRST) && (c_cnt <= C_LAST);
    end

    // Slot counters and registered core outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            t_cnt   <= '0;
            c_cnt   <= '0;
            ffm_a   <= '0;
            ffm_b   <= '0;
            ffm_g   <= '0;
            ffm_ctr <= 1'b0;
        end else begin
            ffm_a   <= a_d;
            ffm_b   <= b_d;
            ffm_g   <= g_d;
            ffm_ctr <= ctr_d;
            if (op_fire) begin
                t_cnt <= '0;
                c_cnt <= '0;
            end else if (state == STREAM) begin
                t_cnt <= t_cnt + 1'b1;
                if (t_cnt != '0) c_cnt <= c_inc;
            end else if (state == WAIT || state == COLLECT) begin
                c_cnt <= c_inc;
            end
        end
    end

`ifdef FFM_OP_COUNT_EN
    // Completed-operation counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (res_fire) begin
            op_count <= op_count + 32'd1;
        end
    end
`else
    logic unused_res_fire;
    assign unused_res_fire = res_fire;
`endif

endmodule

// File: doc/ffm_operand_sequencer.md
Name: ffm_operand_sequencer

Overview:
- Synthesisable word-serial front/back end for the GF(2^m) systolic multiplier core (ports ai/bi/gi/ctr in, po out).
- Accepts full operands A, B, G (N digits of W bits) via valid/ready.
- Streams them MS-digit-first, with B leading A/G by one cycle, then collects N result digits into a parallel word.
- Replaces hand-written stimulus sequencing; parametrised in digit width, digit count and core latency.

Parameters:
- W, 16, digit width in bits (core port width).
- N, 11, digits per operand; operand width N*W.
- RES_DLY, 22, cycles from the first ctr=1 cycle to the first valid po digit.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  operand set offered.
- op_ready  out  1  sequencer can accept an operand set.
- op_a  in  N*W  multiplicand A; digit k = bits [k*W+W-1 : k*W].
- op_b  in  N*W  multiplier B, same digit layout.
- op_g  in  N*W  field polynomial G, same digit layout.
- ffm_ctr  out  1  core control.
- ffm_a  out  W  core ai.
- ffm_b  out  W  core bi.
- ffm_g  out  W  core gi.
- ffm_p  in  W  core po.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  N*W  product; first collected digit lands in digit N-1.

Behaviour:
- Reset: state IDLE, counters 0, op_ready=1 (combinational from IDLE), res_valid=0, res_data=0, ffm_ctr=0, ffm_a/b/g=0. A reset mid-operation aborts it: the next cycle shows these values and the operand/result registers are cleared.
- IDLE: op_ready=1. op_valid&op_ready captures op_a/b/g into internal registers, sets t=0 and moves to STREAM. All core outputs are registered.
- STREAM, cycle t=0..N, core outputs valid during the cycle:
  - t=0: ffm_b=B[N-1], ffm_a=ffm_g=0, ffm_ctr=0.
  - 1<=t<=N-1: ffm_b=B[N-1-t], ffm_a=A[N-t], ffm_g=G[N-t], ffm_ctr=1.
  - t=N: ffm_b=0, ffm_a=A[0], ffm_g=G[0], ffm_ctr=1.
  - After t=N go to WAIT.
- WAIT: ffm_a/b/g=0, ffm_ctr=1. The cycle counter c counts from the t=1 cycle. When c reaches RES_DLY go to COLLECT; when RES_DLY<=N, COLLECT overlaps STREAM and a parallel counter is used (not a state).
- COLLECT: N cycles; each cycle shift ffm_p into res_data from the MS end (first digit ends in digit N-1). ffm_ctr=1, other core outputs 0. Then DONE.
- DONE: res_valid=1, res_data stable, ffm_ctr=0. res_ready=1 moves to IDLE next cycle. op_ready is 0 in every state except IDLE, so back-to-back ops have one idle bubble.
- Total latency, handshake to res_valid: 1+RES_DLY+N cycles.
- Counter widths: $clog2(RES_DLY+N+2).
- op_valid during a busy state is ignored and not latched.
- res_ready outside DONE has no effect.

Optional Feature:
- Macro FFM_OP_COUNT_EN.
- Defined: adds output op_count (32 bits), reset 0, incremented on each res_valid&res_ready, wraps at 2^32.
- Undefined: port and logic absent; otherwise behaviour identical.

Decomposition:
- Package ffm_pkg holds:
  - state enum (IDLE, STREAM, WAIT, COLLECT, DONE);
  - function digit(vec,k) returning W-bit slice k;
  - localparam counter width.
- One sub-module, ffm_digit_shifter: N*W register with parallel load and W-bit shift-out, instantiated for A/G streaming and reused (shift-in mode) for result collection.

Test Plan:
- Reset: after rst held 3 cycles then released -> op_ready=1, res_valid=0, ffm_ctr=0, all core buses 0.
- Ordering (W=16, N=11): A digit k=16'h0A00+k, B=16'h0B00+k, G=16'h0C00+k -> t=0 ffm_b=16'h0B0A, ctr=0; t=1 ffm_a=16'h0A0A, ffm_g=16'h0C0A, ffm_b=16'h0B09; t=11 ffm_a=16'h0A00, ffm_b=0.
- Collection: stub drives ffm_p=16'h1000+c (c = cycles since t=1) -> res_valid at handshake+34; res_data digit 10=16'h1016, digit 0=16'h1020.
- Backpressure: res_ready low 5 cycles in DONE -> res_valid stays 1, res_data unchanged, op_ready=0 despite op_valid=1; accepted exactly one cycle after res_ready pulse.
- Reset mid-op: rst at t=5 -> next cycle ffm_ctr=0, buses 0, op_ready=1; new op then completes normally.
- FFM_OP_COUNT_EN: three completed ops -> op_count=3; reset -> 0.
